// File: rtl/vehicle_detector_if.sv
// Signal bundle between the country-road loop detector and the highway controller.
interface vehicle_detector_if #(
    parameter int unsigned CNT_W = 4
);
    logic             pulse;
    logic             loop_raw;
    logic             enable_countryroad;
    logic             sensor;
    logic [CNT_W-1:0] car_count;
    logic             loop_fault;

    modport master (
        output pulse, loop_raw, enable_countryroad,
        input  sensor, car_count, loop_fault
    );

    modport slave (
        input  pulse, loop_raw, enable_countryroad,
        output sensor, car_count, loop_fault
    );
endinterface

// File: rtl/vehicle_detector.sv
// Country-road inductive-loop detector: synchronise, debounce, count queued vehicles, request service.
// Optional stuck-loop monitor enabled by macro VEHICLE_DETECTOR_STUCK_EN.
module vehicle_detector #(
    parameter int unsigned DEB_CYCLES = 3,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned STUCK_SEC  = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    vehicle_detector_if.slave   bus
);
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        QUEUED  = 2'd1,
        SERVING = 2'd2
    } state_e;

    logic             sync1;
    logic             sync2;
    logic             filt;
    logic [DEB_W-1:0] deb_cnt;
    logic             rise_c;
    logic             depart_c;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt_c;
    state_e           state_q;
    state_e           state_nxt_c;
    logic             sensor_q;
    logic             sensor_nxt_c;
    logic             fault_q;

    // Synchroniser and debounce filter on the raw loop level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            filt    <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.loop_raw;
            sync2 <= sync1;
            if (sync2 == filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                filt    <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Arrival fires on the cycle the filtered level is about to rise, so the count moves with it
    assign rise_c   = sync2 & ~filt & (deb_cnt == DEB_LAST);
    assign depart_c = bus.pulse & bus.enable_countryroad & (count_q != '0);

    always_comb begin
        count_nxt_c = count_q;
        if (rise_c && !depart_c && (count_q != CNT_MAX)) begin
            count_nxt_c = count_q + CNT_W'(1);
        end else if (depart_c && !rise_c) begin
            count_nxt_c = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt_c;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt_c;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt_c = state_q;
        case (state_q)
            EMPTY: begin
                if (rise_c) begin
                    state_nxt_c = bus.enable_countryroad ? SERVING : QUEUED;
                end
            end
            QUEUED: begin
                if (bus.enable_countryroad) begin
                    state_nxt_c = (count_nxt_c == '0) ? EMPTY : SERVING;
                end
            end
            SERVING: begin
                if (count_nxt_c == '0) begin
                    state_nxt_c = EMPTY;
                end else if (!bus.enable_countryroad) begin
                    state_nxt_c = QUEUED;
                end
            end
            default: state_nxt_c = EMPTY;
        endcase
    end

    // FSM output decode; a latched fault keeps the country road requested
    always_comb begin
        sensor_nxt_c = 1'b0;
        if ((state_q == QUEUED) || (state_q == SERVING) || fault_q) begin
            sensor_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sensor_q <= 1'b0;
        end else begin
            sensor_q <= sensor_nxt_c;
        end
    end

`ifdef VEHICLE_DETECTOR_STUCK_EN
    localparam int unsigned STUCK_W = $clog2(STUCK_SEC + 1);

    logic [STUCK_W-1:0] stuck_cnt;

    // Seconds of continuous occupancy; the fault latches until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuck_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (!filt) begin
                stuck_cnt <= '0;
            end else if (bus.pulse && (stuck_cnt != STUCK_W'(STUCK_SEC))) begin
                stuck_cnt <= stuck_cnt + STUCK_W'(1);
            end
            if (filt && bus.pulse && (stuck_cnt == STUCK_W'(STUCK_SEC - 1))) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    logic unused_stuck_cfg;

    // STUCK_SEC has no meaning without the monitor
    assign unused_stuck_cfg = ^32'(STUCK_SEC);
    assign fault_q          = 1'b0;
`endif

    assign bus.sensor     = sensor_q;
    assign bus.car_count  = count_q;
    assign bus.loop_fault = fault_q;
endmodule
